fxp_addsub_pipe: RTL and testbench

Pipelined, parametrised sign-magnitude fixed-point adder/subtractor with valid/ready handshake, per-operation add/subtract select, optional saturation and an overflow event counter. Successor to the team's combinational Q-format adder. Sits in the fixed-point datapath between operand producers (e.g. multiplier outputs, coefficient streams) and downstream accumulators, sustaining one operation per cycle under backpressure.

---
 rtl/fxp_addsub_pipe_if.sv | 24 ++
 rtl/fxp_addsub_pipe.sv | 141 ++++++++++++++
 tb/tb_fxp_addsub_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_addsub_pipe_if.sv
// rtl/fxp_addsub_pipe_if.sv - operand/result handshake bundle for fxp_addsub_pipe
interface fxp_addsub_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, ovf
    );
endinterface

// File: rtl/fxp_addsub_pipe.sv
// rtl/fxp_addsub_pipe.sv - two-stage elastic sign-magnitude fixed-point adder/subtractor
module fxp_addsub_pipe #(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fxp_addsub_pipe_if.slave bus,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] ovf_cnt_o
);
    localparam logic [N-2:0] MAG_MAX = '1;

    // Q only documents the binary point; the arithmetic never looks at it.
    if (Q < 0 || Q >= N - 1) begin : g_bad_q
        $error("fxp_addsub_pipe: Q must satisfy 0 <= Q < N-1");
    end

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_a_q, s1_sign_a_d;
    logic             s1_sign_b_q, s1_sign_b_d;
    logic             s1_same_q, s1_same_d;
    logic             s1_a_gt_q, s1_a_gt_d;
    logic             s1_a_eq_q, s1_a_eq_d;
    logic [N-2:0]     s1_mag_a_q, s1_mag_a_d;
    logic [N-2:0]     s1_mag_b_q, s1_mag_b_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic [N-1:0]     c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_ready;
    logic             in_fire;
    logic             out_fire;
    logic [N-1:0]     sum_w;
    logic [N-2:0]     diff_w;
    logic [N-2:0]     res_mag;
    logic             res_sign;
    logic             res_ovf;

    assign s2_ready     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
    assign ovf_cnt_o     = cnt_q;

    always_comb begin
        s1_valid_d  = in_fire || (s1_valid_q && !s2_ready);
        s1_sign_a_d = s1_sign_a_q;
        s1_sign_b_d = s1_sign_b_q;
        s1_same_d   = s1_same_q;
        s1_a_gt_d   = s1_a_gt_q;
        s1_a_eq_d   = s1_a_eq_q;
        s1_mag_a_d  = s1_mag_a_q;
        s1_mag_b_d  = s1_mag_b_q;
        if (in_fire) begin
            s1_sign_a_d = bus.a[N-1];
            s1_sign_b_d = bus.b[N-1] ^ bus.op;
            s1_same_d   = (bus.a[N-1] == (bus.b[N-1] ^ bus.op));
            s1_mag_a_d  = bus.a[N-2:0];
            s1_mag_b_d  = bus.b[N-2:0];
            s1_a_gt_d   = (bus.a[N-2:0] > bus.b[N-2:0]);
            s1_a_eq_d   = (bus.a[N-2:0] == bus.b[N-2:0]);
        end
    end

    always_comb begin
        sum_w   = {1'b0, s1_mag_a_q} + {1'b0, s1_mag_b_q};
        diff_w  = s1_a_gt_q ? (s1_mag_a_q - s1_mag_b_q) : (s1_mag_b_q - s1_mag_a_q);
        res_ovf = s1_same_q && sum_w[N-1];
        if (s1_same_q) begin
            res_mag  = (res_ovf && SAT) ? MAG_MAX : sum_w[N-2:0];
            res_sign = s1_sign_a_q;
        end else begin
            res_mag  = diff_w;
            res_sign = s1_a_eq_q ? 1'b0 : (s1_a_gt_q ? s1_sign_a_q : s1_sign_b_q);
        end
        // Covers -0 inputs and a wrapped sum that lands on zero.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d   = {res_sign, res_mag};
                ovf_d = res_ovf;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr_i) begin
            cnt_d = '0;
        end else if (out_fire && ovf_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_sign_a_q <= 1'b0;
            s1_sign_b_q <= 1'b0;
            s1_same_q   <= 1'b0;
            s1_a_gt_q   <= 1'b0;
            s1_a_eq_q   <= 1'b0;
            s1_mag_a_q  <= '0;
            s1_mag_b_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            c_q         <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_a_q <= s1_sign_a_d;
            s1_sign_b_q <= s1_sign_b_d;
            s1_same_q   <= s1_same_d;
            s1_a_gt_q   <= s1_a_gt_d;
            s1_a_eq_q   <= s1_a_eq_d;
            s1_mag_a_q  <= s1_mag_a_d;
            s1_mag_b_q  <= s1_mag_b_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// tb/tb_fxp_addsub_pipe.sv - scoreboard bench for fxp_addsub_pipe
module tb_fxp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] cnt_m;
    logic [15:0] cnt_w;
    logic [1:0]  cnt_c;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_out = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    fxp_addsub_pipe_if #(.N(32)) bus_m ();
    fxp_addsub_pipe_if #(.N(32)) bus_w ();
    fxp_addsub_pipe_if #(.N(32)) bus_c ();

    // The wrap and narrow-counter variants follow the main stream in lockstep.
    assign bus_w.in_valid  = bus_m.in_valid;
    assign bus_w.a         = bus_m.a;
    assign bus_w.b         = bus_m.b;
    assign bus_w.op        = bus_m.op;
    assign bus_w.out_ready = bus_m.out_ready;
    assign bus_c.in_valid  = bus_m.in_valid;
    assign bus_c.a         = bus_m.a;
    assign bus_c.b         = bus_m.b;
    assign bus_c.op        = bus_m.op;
    assign bus_c.out_ready = bus_m.out_ready;

    fxp_addsub_pipe #(.N(32), .Q(15), .SAT(1'b1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_m), .ovf_clr_i(ovf_clr), .ovf_cnt_o(cnt_m));
    fxp_addsub_pipe #(.N(32), .Q(15), .SAT(1'b0), .CNT_W(16)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_w), .ovf_clr_i(ovf_clr), .ovf_cnt_o(cnt_w));
    fxp_addsub_pipe #(.N(32), .Q(15), .SAT(1'b1), .CNT_W(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_c), .ovf_clr_i(ovf_clr), .ovf_cnt_o(cnt_c));

    // Reference via signed integer arithmetic: returns {ovf, c}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic op, input bit sat);
        longint va, vb, r, m;
        logic   ov;
        va = longint'(a[30:0]);
        vb = longint'(b[30:0]);
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        r  = op ? (va - vb) : (va + vb);
        m  = (r < 0) ? -r : r;
        ov = (m > 64'h7FFF_FFFF);
        if (ov) m = sat ? 64'h7FFF_FFFF : (m & 64'h7FFF_FFFF);
        return {ov, (r < 0) && (m != 0), m[30:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (bus_m.out_valid && bus_m.out_ready) begin
                n_total++;
                n_out++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got c=%h ovf=%b, required no output", bus_m.c, bus_m.ovf);
                end else if ({bus_m.ovf, bus_m.c} !== sb_q[0]) begin
                    $display("FAIL sb_result: got ovf,c=%h, required %h", {bus_m.ovf, bus_m.c}, sb_q[0]);
                    void'(sb_q.pop_front());
                end else begin
                    n_pass++;
                    void'(sb_q.pop_front());
                end
            end
            if (bus_m.in_valid && bus_m.in_ready)
                sb_q.push_back(model(bus_m.a, bus_m.b, bus_m.op, 1'b1));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic ok;
        int   t;
        bus_m.in_valid = 1'b1;
        bus_m.a = a;
        bus_m.b = b;
        bus_m.op = op;
        t = 0;
        do begin
            @(negedge clk);
            ok = bus_m.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", ok, t);
        end
        bus_m.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({bus_m.out_valid, bus_m.c, bus_m.ovf, cnt_m} !== 50'd0)
            $display("FAIL reset_state: out_valid=%b c=%h ovf=%b cnt=%0d, required all 0",
                     bus_m.out_valid, bus_m.c, bus_m.ovf, cnt_m);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (bus_m.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", bus_m.in_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        send(32'h0000_C000, 32'h0000_2000, 1'b0);
        n_total++;
        if (bus_m.out_valid !== 1'b0) $display("FAIL add_early: out_valid=%b one cycle after handshake, required 0", bus_m.out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (bus_m.out_valid !== 1'b1 || bus_m.c !== 32'h0000_E000 || bus_m.ovf !== 1'b0)
            $display("FAIL add_latency2: out_valid=%b c=%h ovf=%b, required 1 0000e000 0", bus_m.out_valid, bus_m.c, bus_m.ovf);
        else n_pass++;
    endtask

    task automatic test_sub();
        logic [31:0] ta[2] = '{32'h0000_2000, 32'h8000_8000};
        logic [31:0] tb[2] = '{32'h0000_C000, 32'h8000_8000};
        logic [31:0] tc[2] = '{32'h8000_A000, 32'h0000_0000};
        for (int i = 0; i < 2; i++) begin
            send(ta[i], tb[i], 1'b1);
            @(posedge clk);
            #1;
            n_total++;
            if (bus_m.c !== tc[i] || bus_m.ovf !== 1'b0)
                $display("FAIL sub_%0d: c=%h ovf=%b, required %h 0", i, bus_m.c, bus_m.ovf, tc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        logic [31:0] ta[2] = '{32'h0000_8000, 32'h8000_0000};
        logic [31:0] tb[2] = '{32'h8000_8000, 32'h0000_0000};
        for (int i = 0; i < 2; i++) begin
            send(ta[i], tb[i], 1'b0);
            @(posedge clk);
            #1;
            n_total++;
            if (bus_m.c !== 32'h0 || bus_w.c !== 32'h0)
                $display("FAIL zero_%0d: c=%h c_wrap=%h, required 00000000", i, bus_m.c, bus_w.c);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        n_total++;
        if (bus_m.c !== 32'h7FFF_FFFF || bus_m.ovf !== 1'b1)
            $display("FAIL ovf_sat: c=%h ovf=%b, required 7fffffff 1", bus_m.c, bus_m.ovf);
        else n_pass++;
        n_total++;
        if (bus_w.c !== 32'h0000_0000 || bus_w.ovf !== 1'b1)
            $display("FAIL ovf_wrap: c=%h ovf=%b, required 00000000 1", bus_w.c, bus_w.ovf);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (cnt_m !== 16'd1) $display("FAIL ovf_cnt_first: got %0d, required 1", cnt_m);
        else n_pass++;
    endtask

    task automatic test_cnt_sat();
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (cnt_c !== 2'd3 || cnt_m !== 16'd5)
            $display("FAIL cnt_saturate: narrow=%0d wide=%0d, required 3 5", cnt_c, cnt_m);
        else n_pass++;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        n_total++;
        if (cnt_c !== 2'd0 || cnt_m !== 16'd0)
            $display("FAIL cnt_clr_priority: narrow=%0d wide=%0d, required 0 0", cnt_c, cnt_m);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] ta[4] = '{32'h0000_1000, 32'h8000_3000, 32'h0001_0000, 32'h8000_0500};
        logic [31:0] tb[4] = '{32'h0000_0100, 32'h0000_1000, 32'h8000_4000, 32'h8000_0050};
        logic [31:0] c_hold;
        logic [32:0] exp0;
        logic        acc;
        int          idx = 0;
        int          out0 = n_out;
        int          t;
        exp0 = model(ta[0], tb[0], 1'b0, 1'b1);
        c_hold = 32'hx;
        bus_m.out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus_m.in_valid = 1'b1;
            bus_m.a = ta[idx];
            bus_m.b = tb[idx];
            bus_m.op = 1'b0;
            @(negedge clk);
            acc = bus_m.in_ready;
            if (cyc == 2) c_hold = bus_m.c;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        n_total++;
        if (idx !== 2 || bus_m.in_ready !== 1'b0)
            $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2 0", idx, bus_m.in_ready);
        else n_pass++;
        n_total++;
        if (bus_m.c !== c_hold || bus_m.c !== exp0[31:0])
            $display("FAIL bp_stable: c=%h earlier=%h, required %h", bus_m.c, c_hold, exp0[31:0]);
        else n_pass++;
        bus_m.out_ready = 1'b1;
        #1;
        n_total++;
        if (bus_m.in_ready !== 1'b1) $display("FAIL bp_ready_comb: in_ready=%b, required 1", bus_m.in_ready);
        else n_pass++;
        t = 0;
        while (idx < 4 && t < 20) begin
            bus_m.a = ta[idx];
            bus_m.b = tb[idx];
            @(negedge clk);
            acc = bus_m.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            t++;
        end
        bus_m.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (n_out - out0 !== 4 || sb_q.size() !== 0)
            $display("FAIL bp_drain: outputs=%0d pending=%0d, required 4 0", n_out - out0, sb_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int   acc = 0;
        int   cyc = 0;
        logic [31:0] ra;
        while (acc < 10000 && cyc < 60000) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: ra[30:0] = 31'h7FFF_0000 | 31'($urandom_range(0, 65535));
                1: ra[30:0] = 31'($urandom_range(0, 255));
                default: ;
            endcase
            bus_m.a = ra;
            case ($urandom_range(0, 3))
                0: bus_m.b = {1'($urandom), ra[30:0]};
                1: bus_m.b = {1'($urandom), 31'h7FFF_0000 | 31'($urandom_range(0, 65535))};
                default: bus_m.b = $urandom;
            endcase
            bus_m.op = 1'($urandom);
            bus_m.in_valid = ($urandom_range(0, 3) != 0);
            bus_m.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus_m.in_valid && bus_m.in_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_m.in_valid = 1'b0;
        bus_m.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (acc !== 10000 || sb_q.size() !== 0)
            $display("FAIL random_drain: accepted=%0d pending=%0d, required 10000 0", acc, sb_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        bus_m.out_ready = 1'b0;
        bus_m.in_valid = 1'b1;
        bus_m.a = 32'h7FFF_FFFF;
        bus_m.b = 32'h0000_0010;
        bus_m.op = 1'b0;
        while (bus_m.in_ready && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus_m.out_valid !== 1'b0 || cnt_m !== 16'd0 || cnt_c !== 2'd0)
            $display("FAIL reset_async: out_valid=%b cnt=%0d narrow=%0d, required 0 0 0", bus_m.out_valid, cnt_m, cnt_c);
        else n_pass++;
        bus_m.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_m.out_ready = 1'b1;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_m.out_valid) t++;
        end
        n_total++;
        if (t !== 0) $display("FAIL reset_stale: %0d stale outputs, required 0", t);
        else n_pass++;
        @(posedge clk);
        #1;
        send(32'h0000_0300, 32'h8000_0100, 1'b1);
        @(posedge clk);
        #1;
        n_total++;
        if (bus_m.out_valid !== 1'b1 || bus_m.c !== 32'h0000_0400)
            $display("FAIL reset_first_op: out_valid=%b c=%h, required 1 00000400", bus_m.out_valid, bus_m.c);
        else n_pass++;
    endtask

    initial begin
        bus_m.in_valid = 1'b0;
        bus_m.a = '0;
        bus_m.b = '0;
        bus_m.op = 1'b0;
        bus_m.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_add();
        test_sub();
        test_zero();
        test_overflow();
        test_cnt_sat();
        test_backpressure();
        test_random();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
